// File: rtl/pueo_trig_timestamp.sv
// rtl/pueo_trig_timestamp.sv - trigger timestamp capture with record FIFO and valid/ready output
//
// Purpose:
//   Converts single-cycle trigger pulses into timestamp records {event number,
//   PPS second, ticks since last PPS}. Records pass through a one-stage capture
//   register into a first-word fall-through FIFO and leave on a valid/ready stream.
//   A full buffer drops the trigger, counts it, and tags the next accepted record.
//
// Ports:
//   sys_clk_i, sys_rst_n_i  clock and asynchronous active-low reset
//   runrst_i                synchronous run reset (flush, clear counters, WAIT_PPS)
//   trig_i                  one-cycle trigger pulse
//   pps_flag_i              PPS flag; cur_sec_i/last_pps_i update the following cycle
//   cur_sec_i, cur_time_i, last_pps_i  time base from the PPS/time block
//   m_tdata_o  [95:64] event number, [63:32] second, [31:0] subsecond ticks
//   m_tuser_o  [0] sec_valid, [1] drop_before
//   m_tvalid_o, m_tready_i  output stream handshake
//   drop_count_o            saturating dropped-trigger count
//   evt_count_o             accepted-event counter (next event number)

module pueo_trig_timestamp #(
  parameter int FIFO_DEPTH = 16,
  parameter     SYSCLKTYPE = "NONE"
) (
  input  logic        sys_clk_i,
  input  logic        sys_rst_n_i,
  input  logic        runrst_i,
  input  logic        trig_i,
  input  logic        pps_flag_i,
  input  logic [31:0] cur_sec_i,
  input  logic [31:0] cur_time_i,
  input  logic [31:0] last_pps_i,
  output logic [95:0] m_tdata_o,
  output logic [1:0]  m_tuser_o,
  output logic        m_tvalid_o,
  input  logic        m_tready_i,
  output logic [15:0] drop_count_o,
  output logic [31:0] evt_count_o
);

  localparam int AW = $clog2(FIFO_DEPTH);
  // Record layout inside the buffer: [97] drop_before, [96] sec_valid, [95:0] stream data.
  localparam int RW = 98;
  localparam logic [AW+1:0] DEPTH_W = FIFO_DEPTH[AW+1:0];

  // The clock-type tag only documents which domain this block lives in; no logic depends on it.
  if (SYSCLKTYPE != "NONE") begin : g_sysclk_tagged
  end

  typedef enum logic {
    WAIT_PPS = 1'b0,
    RUN      = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [RW-1:0]   mem_q [FIFO_DEPTH];
  logic [RW-1:0]   mem_d [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            cap_valid_q, cap_valid_d;
  logic [RW-1:0]   cap_q, cap_d;
  logic [31:0]     evt_q, evt_d;
  logic [15:0]     drop_q, drop_d;
  logic            drop_pend_q, drop_pend_d;

  logic            pop;
  logic            accept;
  logic [AW+1:0]   occ;
  logic [31:0]     rec_sec;
  logic [31:0]     rec_sub;
  logic            rec_sv;

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cap_valid_d = 1'b0;
    cap_d       = cap_q;
    evt_d       = evt_q;
    drop_d      = drop_q;
    drop_pend_d = drop_pend_q;

    pop = (count_q != '0) && m_tready_i;

    // Occupancy once this edge's write and pop have landed. The pending capture
    // is counted so a record accepted now always finds a free slot next cycle.
    occ = {1'b0, count_q} + {{(AW+1){1'b0}}, cap_valid_q} - {{(AW+1){1'b0}}, pop};
    accept = trig_i && !runrst_i && (occ < DEPTH_W);

    // A trigger coincident with PPS belongs to the new second, which the time
    // block has not published yet.
    rec_sec = pps_flag_i ? (cur_sec_i + 32'd1) : cur_sec_i;
    rec_sub = pps_flag_i ? 32'd0 : (cur_time_i - last_pps_i);
    rec_sv  = (state_q == RUN) || pps_flag_i;

    if (pps_flag_i) begin
      state_d = RUN;
    end

    if (cap_valid_q) begin
      mem_d[wr_ptr_q] = cap_q;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    count_d = count_q + {{AW{1'b0}}, cap_valid_q} - {{AW{1'b0}}, pop};

    if (accept) begin
      cap_valid_d = 1'b1;
      cap_d       = {drop_pend_q, rec_sv, evt_q, rec_sec, rec_sub};
      evt_d       = evt_q + 32'd1;
      drop_pend_d = 1'b0;
    end else if (trig_i && !runrst_i) begin
      if (drop_q != 16'hFFFF) begin
        drop_d = drop_q + 16'd1;
      end
      drop_pend_d = 1'b1;
    end

    // Run reset overrides everything above, including a coincident trigger or PPS.
    if (runrst_i) begin
      state_d     = WAIT_PPS;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      cap_valid_d = 1'b0;
      evt_d       = '0;
      drop_d      = '0;
      drop_pend_d = 1'b0;
    end
  end

  always_ff @(posedge sys_clk_i or negedge sys_rst_n_i) begin
    if (!sys_rst_n_i) begin
      state_q     <= WAIT_PPS;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      cap_valid_q <= 1'b0;
      cap_q       <= '0;
      evt_q       <= '0;
      drop_q      <= '0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      cap_valid_q <= cap_valid_d;
      cap_q       <= cap_d;
      evt_q       <= evt_d;
      drop_q      <= drop_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  // Head of the FIFO is shown directly; gated so idle outputs read as zero.
  assign m_tvalid_o   = (count_q != '0);
  assign m_tdata_o    = m_tvalid_o ? mem_q[rd_ptr_q][95:0]  : 96'd0;
  assign m_tuser_o    = m_tvalid_o ? mem_q[rd_ptr_q][97:96] : 2'd0;
  assign drop_count_o = drop_q;
  assign evt_count_o  = evt_q;

endmodule

// File: tb/tb_pueo_trig_timestamp.sv
// tb/tb_pueo_trig_timestamp.sv - scoreboard bench for pueo_trig_timestamp

module tb_pueo_trig_timestamp;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        runrst;
  logic        trig;
  logic        pps;
  logic [31:0] sec;
  logic [31:0] tm;
  logic [31:0] lp;
  logic [95:0] tdata;
  logic [1:0]  tuser;
  logic        tvalid;
  logic        tready;
  logic [15:0] dcnt;
  logic [31:0] ecnt;

  always #5 clk = ~clk;

  pueo_trig_timestamp #(
    .FIFO_DEPTH(DEPTH),
    .SYSCLKTYPE("NONE")
  ) dut (
    .sys_clk_i   (clk),
    .sys_rst_n_i (rst_n),
    .runrst_i    (runrst),
    .trig_i      (trig),
    .pps_flag_i  (pps),
    .cur_sec_i   (sec),
    .cur_time_i  (tm),
    .last_pps_i  (lp),
    .m_tdata_o   (tdata),
    .m_tuser_o   (tuser),
    .m_tvalid_o  (tvalid),
    .m_tready_i  (tready),
    .drop_count_o(dcnt),
    .evt_count_o (ecnt)
  );

  typedef struct {
    logic [95:0] d;
    logic [1:0]  u;
  } rec_t;

  rec_t        sb[$];
  int          mdl_q[$];
  logic [31:0] m_evt;
  logic [15:0] m_drop;
  bit          m_pend;
  bit          m_run;
  int          cyc;
  int          total;
  int          bad;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic bit mdl_valid(input int c);
    return (mdl_q.size() > 0) && (mdl_q[0] + 2 <= c);
  endfunction

  task automatic model_clear();
    mdl_q.delete();
    sb.delete();
    m_evt  = '0;
    m_drop = '0;
    m_pend = 1'b0;
    m_run  = 1'b0;
  endtask

  // Applies one cycle of stimulus, advances the reference model by that cycle,
  // then checks counters and the valid flag for the following cycle.
  task automatic drive(input bit i_trig, input bit i_pps, input bit i_rr, input bit i_rdy,
                       input logic [31:0] i_sec, input logic [31:0] i_tm, input logic [31:0] i_lp);
    rec_t        r;
    bit          pop;
    int          occ;
    logic [31:0] s;
    logic [31:0] u;
    trig   = i_trig;
    pps    = i_pps;
    runrst = i_rr;
    tready = i_rdy;
    sec    = i_sec;
    tm     = i_tm;
    lp     = i_lp;
    pop = mdl_valid(cyc) && i_rdy;
    occ = mdl_q.size() - (pop ? 1 : 0);
    if (i_rr) begin
      model_clear();
    end else begin
      if (i_trig) begin
        if (occ < DEPTH) begin
          s = i_pps ? i_sec + 32'd1 : i_sec;
          u = i_pps ? 32'd0 : i_tm - i_lp;
          r.d = {m_evt, s, u};
          r.u = {m_pend, m_run | i_pps};
          sb.push_back(r);
          mdl_q.push_back(cyc);
          m_evt  = m_evt + 32'd1;
          m_pend = 1'b0;
        end else begin
          if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
          m_pend = 1'b1;
        end
      end
      if (pop) void'(mdl_q.pop_front());
      if (i_pps) m_run = 1'b1;
    end
    @(posedge clk);
    #1;
    cyc++;
    chk("evt_count", ecnt, m_evt);
    chk("drop_count", dcnt, m_drop);
    chk("tvalid", tvalid, mdl_valid(cyc));
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) drive(0, 0, 0, rdy, 32'd0, 32'd0, 32'd0);
  endtask

  task automatic async_rst();
    rst_n  = 1'b0;
    trig   = 1'b0;
    pps    = 1'b0;
    runrst = 1'b0;
    tready = 1'b0;
    #1;
    model_clear();
    chk("rst_tvalid", tvalid, 0);
    chk("rst_tdata", tdata, 0);
    chk("rst_tuser", tuser, 0);
    chk("rst_drop", dcnt, 0);
    chk("rst_evt", ecnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Monitor: pops the scoreboard on every transfer and checks hold-while-stalled.
  initial begin
    rec_t         r;
    bit           stall = 1'b0;
    bit           rr_prev = 1'b0;
    logic [97:0]  held = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall   = 1'b0;
        rr_prev = 1'b0;
      end else begin
        if (stall && !rr_prev) begin
          chk("hold_valid", tvalid, 1);
          chk("hold_data", {tuser, tdata}, held);
        end
        if (tvalid && tready) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_record actual=%0h required=none", tdata);
          end else begin
            r = sb.pop_front();
            chk("rec_data", tdata, r.d);
            chk("rec_user", tuser, r.u);
          end
        end
        stall   = tvalid && !tready;
        held    = {tuser, tdata};
        rr_prev = runrst;
      end
    end
  end

  initial begin
    bit          rr;
    bit          rdy;
    total  = 0;
    bad    = 0;
    cyc    = 0;
    rst_n  = 1'b0;
    trig   = 1'b0;
    pps    = 1'b0;
    runrst = 1'b0;
    tready = 1'b0;
    sec    = '0;
    tm     = '0;
    lp     = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    async_rst();

    // Basic capture: second 5, 1000-400 ticks.
    drive(0, 0, 1, 1, 32'd0, 32'd0, 32'd0);
    drive(0, 1, 0, 1, 32'd4, 32'd100, 32'd0);
    drive(0, 0, 0, 1, 32'd5, 32'd101, 32'd100);
    drive(1, 0, 0, 1, 32'd5, 32'd1000, 32'd400);
    idle(3, 1);

    // Trigger coincident with PPS, then one tick into the new second.
    drive(1, 1, 0, 1, 32'd7, 32'd2000, 32'd1500);
    drive(1, 0, 0, 1, 32'd8, 32'd2001, 32'd2000);
    idle(3, 1);

    // Pre-PPS trigger and subsecond wrap.
    drive(0, 0, 1, 1, 32'd0, 32'd0, 32'd0);
    drive(1, 0, 0, 1, 32'd3, 32'h0000_0010, 32'hFFFF_FFF0);
    idle(3, 1);

    // Overflow with the consumer stalled.
    drive(0, 0, 1, 0, 32'd0, 32'd0, 32'd0);
    drive(0, 1, 0, 0, 32'd9, 32'd0, 32'd0);
    for (int i = 0; i < 7; i++) drive(1, 0, 0, 0, 32'd10, 32'd500 + i, 32'd100);
    idle(2, 0);
    chk("ovf_evt", ecnt, 4);
    chk("ovf_drop", dcnt, 3);
    drive(1, 0, 0, 1, 32'd10, 32'd900, 32'd100);
    idle(8, 1);

    // Run reset with queued records and a coincident trigger.
    for (int i = 0; i < 3; i++) drive(1, 0, 0, 0, 32'd11, 32'd20 + i, 32'd10);
    idle(2, 0);
    drive(1, 0, 1, 0, 32'd11, 32'd40, 32'd10);
    chk("rr_evt", ecnt, 0);
    chk("rr_drop", dcnt, 0);
    chk("rr_tvalid", tvalid, 0);
    drive(1, 0, 0, 1, 32'd3, 32'd77, 32'd7);
    idle(4, 1);

    // Randomized traffic with backpressure, PPS, run resets and one async reset.
    for (int i = 0; i < 400; i++) begin
      if (i == 200) async_rst();
      rr  = ($urandom_range(99) == 0);
      rdy = rr ? 1'b0 : ($urandom_range(3) != 0);
      drive($urandom_range(1), ($urandom_range(19) == 0), rr, rdy, $urandom, $urandom, $urandom);
    end

    for (int i = 0; i < 64; i++) begin
      if (mdl_q.size() == 0) break;
      idle(1, 1);
    end
    idle(2, 1);
    chk("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
